// File: rtl/writeback_queue_if.sv
// Bundle between the execute/memory stages, the writeback queue and the
// register-file write port. The queue sits on the slave side.
interface writeback_queue_if #(
  parameter int width_p = 32,
  parameter int depth_p = 4,
  parameter int reg_w_p = 5
);
  localparam int cnt_w_lp = $clog2(depth_p) + 1;

  // Upstream completion handshake and operand sources
  logic               in_v_i;
  logic               in_ready_o;
  logic [width_p-1:0] pc_i;
  logic [reg_w_p-1:0] rd_i;
  logic               rd_w_v_i;
  logic [1:0]         src_sel_i;
  logic [width_p-1:0] alu_result_i;
  logic [width_p-1:0] ld_data_i;
  logic [width_p-1:0] csr_data_i;
  logic [1:0]         ld_size_i;
  logic               ld_unsigned_i;
  logic [1:0]         ld_offset_i;

  // Register-file write port
  logic               rf_ready_i;
  logic [reg_w_p-1:0] rd_o;
  logic [width_p-1:0] rd_data_o;
  logic               rd_w_v_o;

  // Forwarding lookup
  logic [reg_w_p-1:0] lookup_rd_i;
  logic               lookup_hit_o;
  logic [width_p-1:0] lookup_data_o;

  // Status
  logic [cnt_w_lp-1:0] count_o;
  logic [31:0]         retired_o;

  modport master (
    output in_v_i, pc_i, rd_i, rd_w_v_i, src_sel_i, alu_result_i, ld_data_i,
           csr_data_i, ld_size_i, ld_unsigned_i, ld_offset_i, rf_ready_i,
           lookup_rd_i,
    input  in_ready_o, rd_o, rd_data_o, rd_w_v_o, lookup_hit_o, lookup_data_o,
           count_o, retired_o
  );

  modport slave (
    input  in_v_i, pc_i, rd_i, rd_w_v_i, src_sel_i, alu_result_i, ld_data_i,
           csr_data_i, ld_size_i, ld_unsigned_i, ld_offset_i, rf_ready_i,
           lookup_rd_i,
    output in_ready_o, rd_o, rd_data_o, rd_w_v_o, lookup_hit_o, lookup_data_o,
           count_o, retired_o
  );
endinterface

// File: rtl/writeback_queue.sv
// In-order writeback queue: forms the destination value at push, holds up to
// depth_p results, retires the head into the register file when granted and
// forwards the youngest pending value for any register.
module writeback_queue #(
  parameter int width_p = 32,
  parameter int depth_p = 4,
  parameter int reg_w_p = 5
) (
  input  logic             clk_i,
  input  logic             rst_i,
  writeback_queue_if.slave bus
);
  localparam int ptr_w_lp = $clog2(depth_p);
  localparam int cnt_w_lp = ptr_w_lp + 1;
  localparam logic [cnt_w_lp-1:0] depth_lp = cnt_w_lp'(depth_p);

  localparam logic [1:0] src_alu_lp  = 2'd0;
  localparam logic [1:0] src_load_lp = 2'd1;
  localparam logic [1:0] src_link_lp = 2'd2;

  localparam logic [1:0] ld_byte_lp = 2'd0;
  localparam logic [1:0] ld_half_lp = 2'd1;
  localparam logic [1:0] ld_word_lp = 2'd2;

  // Entry storage
  logic [reg_w_p-1:0] rd_mem_q   [depth_p];
  logic [width_p-1:0] data_mem_q [depth_p];
  logic               wen_mem_q  [depth_p];

  logic [ptr_w_lp-1:0] rd_ptr_q, rd_ptr_d;
  logic [ptr_w_lp-1:0] wr_ptr_q, wr_ptr_d;
  logic [cnt_w_lp-1:0] count_q, count_d;
  logic [31:0]         retired_q, retired_d;

  logic               empty;
  logic               in_ready;
  logic               push;
  logic               pop;
  logic               head_wen;
  logic [width_p-1:0] push_data;
  logic               push_wen;

  assign empty    = (count_q == '0);
  // Ready depends on registered occupancy only, so a grant arriving this cycle
  // never opens a slot for this cycle's push.
  assign in_ready = (count_q < depth_lp);
  assign head_wen = wen_mem_q[rd_ptr_q];
  assign push     = bus.in_v_i & in_ready;
  assign pop      = ~empty & (~head_wen | bus.rf_ready_i);
  assign push_wen = bus.rd_w_v_i & (bus.rd_i != '0);

  // Destination value formation from the selected source
  always_comb begin
    logic [31:0]        ld_word;
    logic [7:0]         ld_byte;
    logic [15:0]        ld_half;
    logic [width_p-1:0] ld_ext;
    // NOTE: every variable gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    push_data = '0;
    ld_word   = bus.ld_data_i[31:0];
    ld_ext    = '0;
    case (bus.ld_offset_i)
      2'd0:    ld_byte = ld_word[7:0];
      2'd1:    ld_byte = ld_word[15:8];
      2'd2:    ld_byte = ld_word[23:16];
      default: ld_byte = ld_word[31:24];
    endcase
    ld_half = bus.ld_offset_i[1] ? ld_word[31:16] : ld_word[15:0];

    case (bus.ld_size_i)
      ld_byte_lp: begin
        ld_ext      = {width_p{~bus.ld_unsigned_i & ld_byte[7]}};
        ld_ext[7:0] = ld_byte;
      end
      ld_half_lp: begin
        ld_ext       = {width_p{~bus.ld_unsigned_i & ld_half[15]}};
        ld_ext[15:0] = ld_half;
      end
      ld_word_lp: begin
        ld_ext       = {width_p{~bus.ld_unsigned_i & ld_word[31]}};
        ld_ext[31:0] = ld_word;
      end
      default: ld_ext = bus.ld_data_i;
    endcase

    case (bus.src_sel_i)
      src_alu_lp:  push_data = bus.alu_result_i;
      src_load_lp: push_data = ld_ext;
      src_link_lp: push_data = bus.pc_i + width_p'(4);
      default:     push_data = bus.csr_data_i;
    endcase
  end

  // Pointer, occupancy and retire-counter next state
  always_comb begin
    rd_ptr_d  = rd_ptr_q;
    wr_ptr_d  = wr_ptr_q;
    count_d   = count_q;
    retired_d = retired_q;
    if (push) wr_ptr_d = wr_ptr_q + ptr_w_lp'(1);
    if (pop) begin
      rd_ptr_d  = rd_ptr_q + ptr_w_lp'(1);
      retired_d = retired_q + 32'd1;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + cnt_w_lp'(1);
      2'b01:   count_d = count_q - cnt_w_lp'(1);
      default: count_d = count_q;
    endcase
  end

  // Control state registers
  always_ff @(posedge clk_i or negedge rst_i) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    if (!rst_i) begin
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      count_q   <= '0;
      retired_q <= '0;
    end else begin
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      count_q   <= count_d;
      retired_q <= retired_d;
    end
  end

  // Entry storage write on push
  always_ff @(posedge clk_i) begin
    // NOTE: entry storage is not reset; occupancy alone decides validity, and
    // every output derived from an entry is gated by it.
    if (push) begin
      rd_mem_q[wr_ptr_q]   <= bus.rd_i;
      data_mem_q[wr_ptr_q] <= push_data;
      wen_mem_q[wr_ptr_q]  <= push_wen;
    end
  end

  // Youngest-match forwarding over valid entries, walked oldest to youngest
  always_comb begin
    logic [ptr_w_lp-1:0] idx;
    bus.lookup_hit_o  = 1'b0;
    bus.lookup_data_o = '0;
    idx               = rd_ptr_q;
    for (int k = 0; k < depth_p; k++) begin
      idx = rd_ptr_q + ptr_w_lp'(k);
      if ((cnt_w_lp'(k) < count_q) && wen_mem_q[idx] &&
          (rd_mem_q[idx] == bus.lookup_rd_i) && (bus.lookup_rd_i != '0)) begin
        bus.lookup_hit_o  = 1'b1;
        bus.lookup_data_o = data_mem_q[idx];
      end
    end
  end

  assign bus.in_ready_o = in_ready;
  assign bus.rd_w_v_o   = ~empty & head_wen;
  assign bus.rd_o       = empty ? '0 : rd_mem_q[rd_ptr_q];
  assign bus.rd_data_o  = empty ? '0 : data_mem_q[rd_ptr_q];
  assign bus.count_o    = count_q;
  assign bus.retired_o  = retired_q;

endmodule
